h75_fb_write_arbiter: RTL and testbench

- Sequences and shares the single framebuffer write port of the HUB75 top-level between two requesters: the APB register path and an internal rectangular-fill engine.
- Also owns double-buffer page selection:
  - Writes always target the back page.
  - `display_page` selects the front page.
  - Page swaps are committed only on `frame_sync`, so no frame ever shows a half-written image.
- Output drives `wr_en`, `wr_addr[14:0]` and `wr_data` of the display module directly.

---
 rtl/h75_fb_write_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_h75_fb_write_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h75_fb_write_arbiter.sv
// h75_fb_write_arbiter
// Shares the single framebuffer write port between the APB register path
// (via a one-deep holding register) and a rectangular-fill engine, and owns
// double-buffer page selection. Writes always land on the back page; page
// swaps commit only on frame_sync.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   apb_wr_valid/ready/addr/data APB write request channel
//   fill_start/base/count/data   fill command (start is a pulse)
//   fill_busy, fill_done         fill engine status
//   swap_req, frame_sync         page swap request / frame boundary strobe
//   swap_pending, display_page   swap status / front page index
//   wr_en, wr_addr, wr_data      framebuffer write port (wr_addr MSB = page)
module h75_fb_write_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              apb_wr_valid,
  output logic              apb_wr_ready,
  input  logic [ADDR_W-1:0] apb_wr_addr,
  input  logic [DATA_W-1:0] apb_wr_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_count,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              swap_req,
  input  logic              frame_sync,
  output logic              swap_pending,
  output logic              display_page,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fill_state_t;

  typedef enum logic {
    G_APB  = 1'b0,
    G_FILL = 1'b1
  } grant_t;

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic              hold_full_q, hold_full_d;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;
  grant_t            last_grant_q;

  logic              fill_req_c;
  logic              gnt_apb_c;
  logic              gnt_fill_c;
  logic              accept_c;
  logic              commit_c;
  logic              page_d;
  logic              pending_d;
  logic [CNT_W-1:0]  idx_inc_c;
  logic [ADDR_W-1:0] fill_addr_c;

  assign fill_req_c  = (state_q == S_RUN);
  assign accept_c    = apb_wr_valid & apb_wr_ready;
  assign idx_inc_c   = idx_q + CNT_W'(1);
  // Address arithmetic wraps naturally inside one page.
  assign fill_addr_c = base_q + idx_q[ADDR_W-1:0];

  // Round-robin arbitration: on contention the requester not granted last wins.
  always_comb begin
    gnt_apb_c  = 1'b0;
    gnt_fill_c = 1'b0;
    if (hold_full_q && fill_req_c) begin
      gnt_apb_c  = (last_grant_q == G_FILL);
      gnt_fill_c = (last_grant_q == G_APB);
    end else begin
      gnt_apb_c  = hold_full_q;
      gnt_fill_c = fill_req_c;
    end
  end

  // Holding register occupancy and page-swap bookkeeping.
  always_comb begin
    hold_full_d = accept_c | (hold_full_q & ~gnt_apb_c);
    commit_c    = frame_sync & swap_pending;
    page_d      = display_page ^ commit_c;
    // A request coinciding with a commit is queued for the next frame.
    pending_d   = swap_req | (swap_pending & ~commit_c);
  end

  // Fill FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      fdata_q <= fdata_d;
    end
  end

  // Fill FSM next state.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    fdata_d = fdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          base_d  = fill_base;
          count_d = fill_count;
          fdata_d = fill_data;
          idx_d   = '0;
          state_d = (fill_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (gnt_fill_c) begin
          idx_d = idx_inc_c;
          if (idx_inc_c == count_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // APB holding register and arbitration history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_full_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      last_grant_q <= G_FILL;
    end else begin
      hold_full_q <= hold_full_d;
      if (accept_c) begin
        hold_addr_q <= apb_wr_addr;
        hold_data_q <= apb_wr_data;
      end
      if (gnt_apb_c) begin
        last_grant_q <= G_APB;
      end else if (gnt_fill_c) begin
        last_grant_q <= G_FILL;
      end
    end
  end

  // Registered outputs; writes target the back page as seen after this cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      apb_wr_ready <= 1'b0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
      swap_pending <= 1'b0;
      display_page <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      apb_wr_ready <= ~hold_full_d;
      fill_busy    <= (state_d != S_IDLE);
      fill_done    <= (state_d == S_DONE);
      swap_pending <= pending_d;
      display_page <= page_d;
      wr_en        <= gnt_apb_c | gnt_fill_c;
      if (gnt_apb_c) begin
        wr_addr <= {~page_d, hold_addr_q};
        wr_data <= hold_data_q;
      end else if (gnt_fill_c) begin
        wr_addr <= {~page_d, fill_addr_c};
        wr_data <= fdata_q;
      end
    end
  end

endmodule

// File: tb/tb_h75_fb_write_arbiter.sv
// Self-checking bench for h75_fb_write_arbiter: directed stimulus pushes the
// expected framebuffer writes into queues; a negedge monitor pops and compares.
module tb_h75_fb_write_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              resetn;
  logic              apb_wr_valid;
  logic              apb_wr_ready;
  logic [ADDR_W-1:0] apb_wr_addr;
  logic [DATA_W-1:0] apb_wr_data;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W:0]   fill_count;
  logic [DATA_W-1:0] fill_data;
  logic              fill_busy;
  logic              fill_done;
  logic              swap_req;
  logic              frame_sync;
  logic              swap_pending;
  logic              display_page;
  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;

  h75_fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .apb_wr_valid (apb_wr_valid),
    .apb_wr_ready (apb_wr_ready),
    .apb_wr_addr  (apb_wr_addr),
    .apb_wr_data  (apb_wr_data),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_count   (fill_count),
    .fill_data    (fill_data),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .swap_req     (swap_req),
    .frame_sync   (frame_sync),
    .swap_pending (swap_pending),
    .display_page (display_page),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_apb[$];
  wr_t exp_fill[$];
  int  n_checks    = 0;
  int  n_fail      = 0;
  int  fill_writes = 0;
  int  apb_writes  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input logic [ADDR_W-1:0] base, input int count,
                           input logic [DATA_W-1:0] data, input logic msb);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < count; i++) begin
      a = base + ADDR_W'(i);
      exp_fill.push_back({msb, a, data});
    end
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic msb);
    int w;
    w = 0;
    while (!apb_wr_ready && w < 20) begin
      tick();
      w++;
    end
    check("apb_ready_wait", 32'(apb_wr_ready), 32'd1);
    apb_wr_valid = 1'b1;
    apb_wr_addr  = addr;
    apb_wr_data  = data;
    exp_apb.push_back({msb, addr, data});
    tick();
    apb_wr_valid = 1'b0;
  endtask

  task automatic start_fill(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count,
                            input logic [DATA_W-1:0] data);
    fill_start = 1'b1;
    fill_base  = base;
    fill_count = count;
    fill_data  = data;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_fill_done(input string name, input int limit, output int cyc);
    cyc = 0;
    while (!fill_done && cyc < limit) begin
      tick();
      cyc++;
    end
    check(name, 32'(fill_done), 32'd1);
  endtask

  // Scoreboard monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      if (exp_fill.size() > 0 && wr_data == exp_fill[0].data) begin
        e = exp_fill.pop_front();
        fill_writes++;
        check("wr_addr_fill", 32'(wr_addr), 32'(e.addr));
      end else if (exp_apb.size() > 0) begin
        e = exp_apb.pop_front();
        apb_writes++;
        check("wr_addr_apb", 32'(wr_addr), 32'(e.addr));
        check("wr_data_apb", wr_data, e.data);
      end else begin
        check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n_acc;
    int wr_cycles;
    bit acc;
    bit seen;

    resetn       = 1'b0;
    apb_wr_valid = 1'b0;
    apb_wr_addr  = '0;
    apb_wr_data  = '0;
    fill_start   = 1'b0;
    fill_base    = '0;
    fill_count   = '0;
    fill_data    = '0;
    swap_req     = 1'b0;
    frame_sync   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_ready", 32'(apb_wr_ready), 32'd0);
    check("rst_page", 32'(display_page), 32'd0);
    check("rst_pending", 32'(swap_pending), 32'd0);
    check("rst_busy", 32'(fill_busy), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    resetn = 1'b1;
    tick();
    check("ready_after_rst", 32'(apb_wr_ready), 32'd1);

    // Single APB write: wr_en exactly two cycles after accept
    apb_wr_valid = 1'b1;
    apb_wr_addr  = 14'h0123;
    apb_wr_data  = 32'hDEADBEEF;
    exp_apb.push_back({15'h4123, 32'hDEADBEEF});
    tick();
    apb_wr_valid = 1'b0;
    check("apb_ready_low", 32'(apb_wr_ready), 32'd0);
    check("apb_wr_en_n1", 32'(wr_en), 32'd0);
    tick();
    check("apb_wr_en_n2", 32'(wr_en), 32'd1);
    check("apb_ready_back", 32'(apb_wr_ready), 32'd1);
    tick();
    check("apb_wr_en_n3", 32'(wr_en), 32'd0);

    // Fill with wrap at the top of the page
    exp_fill.push_back({15'h7FFE, 32'h00005A5A});
    exp_fill.push_back({15'h7FFF, 32'h00005A5A});
    exp_fill.push_back({15'h4000, 32'h00005A5A});
    exp_fill.push_back({15'h4001, 32'h00005A5A});
    start_fill(14'h3FFE, 15'd4, 32'h00005A5A);
    check("fill4_busy", 32'(fill_busy), 32'd1);
    check("fill4_wr_en0", 32'(wr_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fill4_wr_en", 32'(wr_en), 32'd1);
      check("fill4_done", 32'(fill_done), (i == 3) ? 32'd1 : 32'd0);
    end
    check("fill4_busy_done", 32'(fill_busy), 32'd1);
    tick();
    check("fill4_done_off", 32'(fill_done), 32'd0);
    check("fill4_busy_off", 32'(fill_busy), 32'd0);
    check("fill4_wr_en_off", 32'(wr_en), 32'd0);

    // Fill of 100 words contended by a continuous APB stream
    push_fill(14'h0100, 100, 32'h0000C0DE, 1'b1);
    fill_start   = 1'b1;
    fill_base    = 14'h0100;
    fill_count   = 15'd100;
    fill_data    = 32'h0000C0DE;
    apb_wr_valid = 1'b1;
    apb_wr_addr  = 14'h2000;
    apb_wr_data  = 32'hA000_0000;
    cyc = 0;
    n_acc = 0;
    wr_cycles = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      acc = apb_wr_valid && apb_wr_ready;
      if (acc) exp_apb.push_back({1'b1, apb_wr_addr, apb_wr_data});
      tick();
      fill_start = 1'b0;
      cyc++;
      if (acc) begin
        n_acc++;
        apb_wr_addr = apb_wr_addr + 14'd1;
        apb_wr_data = apb_wr_data + 32'd1;
      end
      if (wr_en) wr_cycles++;
      if (fill_done) seen = 1'b1;
    end
    apb_wr_valid = 1'b0;
    check("mix_done_seen", 32'(seen), 32'd1);
    check("mix_done_cycle", 32'(cyc), 32'd201);
    check("mix_apb_accepts", 32'(n_acc), 32'd101);
    check("mix_wr_cycles", 32'(wr_cycles), 32'd200);
    repeat (4) tick();
    check("mix_fill_writes", 32'(fill_writes), 32'd104);
    check("mix_apb_writes", 32'(apb_writes), 32'd102);

    // Swap request committed on a later frame_sync
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("swap_pending_wait", 32'(swap_pending), 32'd1);
      check("swap_page_wait", 32'(display_page), 32'd0);
      tick();
    end
    frame_sync = 1'b1;
    check("swap_pending_fs", 32'(swap_pending), 32'd1);
    tick();
    frame_sync = 1'b0;
    check("swap_page_commit", 32'(display_page), 32'd1);
    check("swap_pending_clr", 32'(swap_pending), 32'd0);
    apb_write(14'h0055, 32'h1234_5678, 1'b0);
    push_fill(14'h0010, 2, 32'h0000F00D, 1'b0);
    start_fill(14'h0010, 15'd2, 32'h0000F00D);
    wait_fill_done("swap_fill_done", 20, cyc);
    tick();

    // Request coinciding with frame_sync while nothing pending
    swap_req   = 1'b1;
    frame_sync = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_sync = 1'b0;
    check("coinc_page", 32'(display_page), 32'd1);
    check("coinc_pending", 32'(swap_pending), 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("coinc_next_page", 32'(display_page), 32'd0);
    check("coinc_next_pending", 32'(swap_pending), 32'd0);

    // Request in the commit cycle is queued for the next frame
    swap_req = 1'b1;
    tick();
    frame_sync = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_sync = 1'b0;
    check("requeue_page", 32'(display_page), 32'd1);
    check("requeue_pending", 32'(swap_pending), 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("requeue_page2", 32'(display_page), 32'd0);

    // Multiple requests collapse into a single swap
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    swap_req = 1'b1;
    tick();
    swap_req   = 1'b0;
    frame_sync = 1'b1;
    tick();
    check("collapse_page", 32'(display_page), 32'd1);
    tick();
    frame_sync = 1'b0;
    check("collapse_page_hold", 32'(display_page), 32'd1);
    check("collapse_pending", 32'(swap_pending), 32'd0);

    // Zero-length fill
    start_fill(14'h0300, 15'd0, 32'h0000_0BAD);
    check("fill0_done", 32'(fill_done), 32'd1);
    check("fill0_wr_en", 32'(wr_en), 32'd0);
    tick();
    check("fill0_done_off", 32'(fill_done), 32'd0);
    check("fill0_busy_off", 32'(fill_busy), 32'd0);

    // Reset in the middle of a 50-word fill
    push_fill(14'h0200, 9, 32'hBEEF_0000, 1'b0);
    start_fill(14'h0200, 15'd50, 32'hBEEF_0000);
    repeat (9) tick();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_done", 32'(fill_done), 32'd0);
      check("abort_busy", 32'(fill_busy), 32'd0);
    end
    check("abort_page", 32'(display_page), 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    check("abort_ready", 32'(apb_wr_ready), 32'd0);
    resetn = 1'b1;
    tick();
    check("abort_ready_back", 32'(apb_wr_ready), 32'd1);
    check("abort_fill_writes", 32'(fill_writes), 32'd115);

    // A fresh fill after reset runs normally on back page 1
    push_fill(14'h0007, 3, 32'h0000_0077, 1'b1);
    start_fill(14'h0007, 15'd3, 32'h0000_0077);
    wait_fill_done("post_rst_done", 20, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd3);
    repeat (5) tick();

    check("exp_apb_empty", 32'(exp_apb.size()), 32'd0);
    check("exp_fill_empty", 32'(exp_fill.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
